// File: rtl/gray_pulse_gen_if.sv
// Count/handshake bundle between a pulse-count source and gray_pulse_gen.
// The block itself takes the slave side; the source takes the master side.
interface gray_pulse_gen_if #(
   parameter int unsigned WIDTH = 8
);
   logic             in_valid;
   logic [WIDTH-1:0] in_gray;
   logic             in_ready;
   logic             pulse;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] remaining;

   modport master (
      output in_valid, in_gray,
      input  in_ready, pulse, busy, done, remaining
   );

   modport slave (
      input  in_valid, in_gray,
      output in_ready, pulse, busy, done, remaining
   );
endinterface

// File: rtl/gray_pulse_gen.sv
// Accepts a Gray-coded count and emits that many single-cycle pulses,
// separated by GAP idle cycles, followed by a one-cycle done strobe.
module gray_pulse_gen #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned GAP   = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   gray_pulse_gen_if.slave  bus
);

   localparam int unsigned GCW      = (GAP > 0) ? $clog2(GAP + 1) : 1;
   localparam bit          HAS_GAP  = (GAP != 0);
   localparam logic [GCW-1:0] GAP_LAST = GCW'((GAP > 0) ? (GAP - 1) : 0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EMIT = 2'd1,
      GAPW = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [GCW-1:0]   gap_q, gap_d;
   logic             live_q;
   logic             ready_c;
   logic             accept_c;
   logic [WIDTH-1:0] bin_c;

   function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   assign bin_c    = gray2bin(bus.in_gray);
   // live_q keeps in_ready low until the first edge after reset release
   assign ready_c  = (state_q == IDLE) && enable && live_q;
   assign accept_c = bus.in_valid && ready_c;

   // State and counter registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         rem_q   <= '0;
         gap_q   <= '0;
         live_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         gap_q   <= gap_d;
         live_q  <= 1'b1;
      end
   end

   // Next-state and counter update; enable low freezes everything
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      gap_d   = gap_q;
      if (enable) begin
         case (state_q)
            IDLE: begin
               if (accept_c) begin
                  rem_d   = bin_c;
                  state_d = (bin_c != '0) ? EMIT : DONE;
               end
            end
            EMIT: begin
               rem_d = rem_q - WIDTH'(1);
               if (rem_q == WIDTH'(1)) begin
                  state_d = DONE;
               end else if (HAS_GAP) begin
                  gap_d   = '0;
                  state_d = GAPW;
               end else begin
                  state_d = EMIT;
               end
            end
            GAPW: begin
               if (gap_q == GAP_LAST) begin
                  gap_d   = '0;
                  state_d = EMIT;
               end else begin
                  gap_d = gap_q + GCW'(1);
               end
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = ready_c;
   assign bus.pulse     = (state_q == EMIT);
   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = (state_q == DONE);
   assign bus.remaining = rem_q;

endmodule
